// File: rtl/data_key_search.sv
`default_nettype none
// ============================================================================
// Module   : data_key_search
// Purpose  : Reverse lookup table. Holds NR_KEY entries of {valid, key, data}
//            and, for a requested data value, returns the key and index of the
//            lowest-indexed valid entry whose data matches (data in, key out).
//            One entry is compared per clock; result is held until consumed.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            wr_en/wr_idx/wr_key/wr_data - single-entry table write
//            clr                   - invalidate all entries (wins over wr_en)
//            req_valid/req_ready/req_data - search request handshake
//            resp_valid/resp_ready - response handshake
//            resp_hit/resp_key/resp_idx - search result (key/idx 0 on miss)
// Revision : 1.0 - initial release
// ============================================================================
module data_key_search #(
  parameter int NR_KEY   = 8,
  parameter int KEY_LEN  = 4,
  parameter int DATA_LEN = 8,
  localparam int IW = ($clog2(NR_KEY) > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IW-1:0]       wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                clr,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_hit,
  output logic [KEY_LEN-1:0]  resp_key,
  output logic [IW-1:0]       resp_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NR_KEY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Table storage. Each entry owns its registers; flattened views feed the
  // scan multiplexer. Indices with no matching entry are simply never written,
  // so out-of-range wr_idx values fall away naturally.
  // --------------------------------------------------------------------------
  logic [NR_KEY-1:0]   ent_valid;
  logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
  logic [DATA_LEN-1:0] ent_data [NR_KEY];

  for (genvar g = 0; g < NR_KEY; g++) begin : g_entry
    logic                valid_q;
    logic [KEY_LEN-1:0]  key_q;
    logic [DATA_LEN-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        key_q   <= '0;
        data_q  <= '0;
      end else if (clr) begin
        // clr dominates a simultaneous write: entry ends up invalid
        valid_q <= 1'b0;
      end else if (wr_en && (wr_idx == IW'(g))) begin
        valid_q <= 1'b1;
        key_q   <= wr_key;
        data_q  <= wr_data;
      end
    end

    assign ent_valid[g] = valid_q;
    assign ent_key[g]   = key_q;
    assign ent_data[g]  = data_q;
  end

  // --------------------------------------------------------------------------
  // Search FSM
  // --------------------------------------------------------------------------
  state_t              state;
  logic [IW-1:0]       scan_idx;
  logic [DATA_LEN-1:0] req_q;
  logic                match;

  // Compare uses the table as registered before this edge, so a write landing
  // on the entry under comparison in the same cycle is not observed.
  assign match = ent_valid[scan_idx] && (ent_data[scan_idx] == req_q);

  // Held low while in reset even though the state register reads IDLE.
  assign req_ready = rst_n && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      scan_idx   <= '0;
      req_q      <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      resp_key   <= '0;
      resp_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q    <= req_data;
            scan_idx <= '0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (match) begin
            resp_hit   <= 1'b1;
            resp_key   <= ent_key[scan_idx];
            resp_idx   <= scan_idx;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (scan_idx == LAST_IDX) begin
            resp_hit   <= 1'b0;
            resp_key   <= '0;
            resp_idx   <= '0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            scan_idx <= scan_idx + IW'(1);
          end
        end
        RESP: begin
          // req_ready is low here, so a new request cannot be taken until
          // the cycle after the response handshake.
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
